ifid_fetch_queue: RTL and testbench
===================================

// Module: ifid_fetch_queue
// PURPOSE
//  Parametrised successor to the single-entry IF/ID latch: a DEPTH-entry fetch queue between the IF stage and ID.
//  Each entry holds {Instruction, PCAdd4, PC, IsBDS}.
//  Decouples fetch from decode stalls. Supports whole-queue flush on redirect/exception.
//  Drives a NOP bubble to ID when empty.
// PARAMETERS
//  DEPTH    2   entries; power of two, >=2
//  PC_W     32  width of PC and PCAdd4
//  INSTR_W  32  instruction width
// PORTS
//  clock           in   1        sole clock; all state updates on posedge
//  reset           in   1        synchronous, active-high
//  IF_Valid        in   1        IF presents a fetched instruction this cycle
//  IF_Ready        out  1        queue accepts an entry this cycle
//  IF_Instruction  in   INSTR_W  fetched instruction
//  IF_PCAdd4       in   PC_W     PC+4 of the fetched instruction
//  IF_PCOut        in   PC_W     PC of the fetched instruction
//  IF_IsBDS        in   1        instruction sits in a branch delay slot
//  IF_Flush        in   1        discard all entries plus any same-cycle push
//  ID_Stall        in   1        ID cannot consume this cycle
//  ID_Valid        out  1        head entry valid
//  ID_Instruction  out  INSTR_W  head instruction; 0 (NOP) when !ID_Valid
//  ID_PCAdd4       out  PC_W     head PC+4; 0 when !ID_Valid
//  ID_PC           out  PC_W     head PC; 0 when !ID_Valid
//  ID_IsBDS        out  1        head BDS flag; 0 when !ID_Valid
//  Count           out  $clog2(DEPTH+1)  occupied entries
// BEHAVIOUR
//  - Reset: rd/wr pointers 0, Count=0, ID_Valid=0, all ID_* data 0, IF_Ready=1 on the first cycle after reset.
//  - push = IF_Valid & IF_Ready & !IF_Flush. pop = ID_Valid & !ID_Stall & !IF_Flush.
//  - IF_Ready = (Count != DEPTH). No pass-through when full: with full+pop, IF_Ready stays 0 that cycle.
//  - Storage: circular buffer.
//    - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
//    - Count += push - pop. Simultaneous push+pop leaves Count unchanged.
//  - Latency: a push into an empty queue is visible at ID_Valid the next cycle.
//  - Order: strict FIFO. IsBDS travels with its instruction, never reordered.
//  - Flush (highest priority, below reset):
//    - Next cycle Count=0, pointers 0, ID_Valid=0.
//    - Same-cycle push and pop are both dropped.
//    - IF_Ready is unaffected by flush in the flush cycle itself.
//  - ID_Stall with ID_Valid=1: head and all ID_* outputs hold stable.
//  - ID_Stall with empty queue: no effect.
//  - ID_* data are muxed from the head entry and gated to 0 when !ID_Valid. A bubble decodes as SLL r0,r0,0.
//  - Reset asserted mid-operation: identical to power-on reset; in-flight push ignored.
//  - X on IF_* data while IF_Valid=0 must never reach ID_*.
// CONFIGURATION
//  IFQ_BYPASS_EN defined:
//   - Condition: queue empty, push, and !ID_Stall.
//   - Effect: IF_* fields drive ID_* combinationally the same cycle with ID_Valid=1. The entry is not written; Count stays 0.
//   - Empty + push + ID_Stall: the entry is written normally.
//   - Bypass is suppressed when IF_Flush=1.
//  IFQ_BYPASS_EN undefined:
//   - Minimum latency is 1 cycle.
//   - ID_* depend only on registered state; no IF->ID combinational path.
// TESTING
//  1. Reset: hold reset 2 cycles with IF_Valid=1 -> Count=0, ID_Valid=0, ID_Instruction=0, IF_Ready=1.
//  2. Fill/drain, DEPTH=2, ID_Stall=1:
//     - Push PC 0x100, then 0x104 -> Count=2, IF_Ready=0.
//     - Third push refused.
//     - Release stall -> ID_PC 0x100 then 0x104 on consecutive cycles, then ID_Valid=0.
//  3. Wrap-around: DEPTH=4, 10 back-to-back push+pop with PC 0x0..0x24 step 4 -> outputs in order, Count stays 1, no loss.
//  4. Flush:
//     - Setup: Count=2, IF_Valid=1, IF_Flush=1.
//     - Expect next cycle: Count=0, ID_Valid=0, and the pushed instruction never appears.
//  5. BDS tag: push branch (IsBDS=0) then slot (IsBDS=1, PC 0x204) -> ID_IsBDS=1 only with ID_PC=0x204.
//  6. Bypass: with IFQ_BYPASS_EN, push 0x8C010004 into empty queue, ID_Stall=0.
//     - Expect: ID_Valid=1 and ID_Instruction=0x8C010004 in the same cycle, Count=0.
//     - Without the macro: appears one cycle later.

Source files
------------

// File: rtl/ifid_fetch_queue_if.sv
// ifid_fetch_queue_if
//   Bundles the IF-side push port and the ID-side head port of the fetch queue.
//   Handshake: an entry moves IF -> queue on a rising clock edge where IF_Valid=1,
//   IF_Ready=1 and IF_Flush=0. The head entry moves queue -> ID on a rising edge
//   where ID_Valid=1, ID_Stall=0 and IF_Flush=0. IF_Ready is a function of queue
//   occupancy only and never looks at IF_Valid. ID_Valid is a function of queue
//   occupancy only, except in the IFQ_BYPASS_EN build, where it may also follow
//   IF_Valid combinationally when the queue is empty.
//   modport slave  : the queue itself
//   modport master : the surrounding fetch/decode logic driving the queue

interface ifid_fetch_queue_if #(
  parameter int DEPTH   = 2,
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // IF side
  logic               IF_Valid;
  logic               IF_Ready;
  logic [INSTR_W-1:0] IF_Instruction;
  logic [PC_W-1:0]    IF_PCAdd4;
  logic [PC_W-1:0]    IF_PCOut;
  logic               IF_IsBDS;
  logic               IF_Flush;

  // ID side
  logic               ID_Stall;
  logic               ID_Valid;
  logic [INSTR_W-1:0] ID_Instruction;
  logic [PC_W-1:0]    ID_PCAdd4;
  logic [PC_W-1:0]    ID_PC;
  logic               ID_IsBDS;

  // occupancy
  logic [CNT_W-1:0]   Count;

  modport slave (
    input  IF_Valid, IF_Instruction, IF_PCAdd4, IF_PCOut, IF_IsBDS, IF_Flush,
    input  ID_Stall,
    output IF_Ready,
    output ID_Valid, ID_Instruction, ID_PCAdd4, ID_PC, ID_IsBDS,
    output Count
  );

  modport master (
    output IF_Valid, IF_Instruction, IF_PCAdd4, IF_PCOut, IF_IsBDS, IF_Flush,
    output ID_Stall,
    input  IF_Ready,
    input  ID_Valid, ID_Instruction, ID_PCAdd4, ID_PC, ID_IsBDS,
    input  Count
  );

endinterface

// File: rtl/ifid_fetch_queue.sv
// ifid_fetch_queue
//   DEPTH-entry circular fetch queue between the IF and ID stages. Each entry
//   carries {Instruction, PCAdd4, PC, IsBDS} so the delay-slot tag can never be
//   separated from its instruction. When the queue is empty, ID sees a bubble:
//   ID_Valid=0 and all ID data 0, which decodes as SLL r0,r0,0.
//   IF_Flush empties the queue (pointers and count back to 0) and drops any
//   same-cycle push and pop.
//   Optional feature macro: IFQ_BYPASS_EN. When defined, an instruction pushed
//   into an empty queue while ID is not stalled is forwarded combinationally to
//   ID in the same cycle and is never written into storage. When undefined, the
//   ID outputs are a function of registered state only.

module ifid_fetch_queue #(
  parameter int DEPTH   = 2,
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input logic               clock,
  input logic               reset,
  ifid_fetch_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Entry storage, split per field; read is an asynchronous mux on rd_ptr.
  logic [INSTR_W-1:0] mem_instr  [DEPTH];
  logic [PC_W-1:0]    mem_pcadd4 [DEPTH];
  logic [PC_W-1:0]    mem_pc     [DEPTH];
  logic               mem_bds    [DEPTH];

  // Pointers are exactly PTR_W bits, so increments wrap DEPTH-1 -> 0 for free.
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic wr_en;
  logic rd_en;
  logic id_valid;
`ifdef IFQ_BYPASS_EN
  logic bypass;
`endif

  // Handshake qualification: push/pop, plus whether storage is touched.
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == FULL_CNT);
    // No pass-through when full: a same-cycle pop does not free a slot for IF.
    push  = bus.IF_Valid & ~full & ~bus.IF_Flush;
`ifdef IFQ_BYPASS_EN
    // Forward straight to ID only when nothing is queued ahead and ID will take
    // it this cycle; with a stall the entry is stored like any other push.
    bypass   = empty & push & ~bus.ID_Stall;
    id_valid = ~empty | bypass;
    pop      = id_valid & ~bus.ID_Stall & ~bus.IF_Flush;
    // A bypassed entry is both pushed and popped in the same cycle, so it never
    // occupies storage and the count stays at 0.
    wr_en    = push & ~bypass;
    rd_en    = pop & ~bypass;
`else
    id_valid = ~empty;
    pop      = id_valid & ~bus.ID_Stall & ~bus.IF_Flush;
    wr_en    = push;
    rd_en    = pop;
`endif
  end

  // Pointer and occupancy registers; reset and flush both return to empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (bus.IF_Flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry write at the tail. Storage contents need no reset: they are only
  // visible through the ID_Valid gate below.
  always_ff @(posedge clock) begin
    if (!reset && wr_en) begin
      mem_instr[wr_ptr]  <= bus.IF_Instruction;
      mem_pcadd4[wr_ptr] <= bus.IF_PCAdd4;
      mem_pc[wr_ptr]     <= bus.IF_PCOut;
      mem_bds[wr_ptr]    <= bus.IF_IsBDS;
    end
  end

  // ID outputs: head entry when queued, forwarded IF fields when bypassing,
  // otherwise an all-zero bubble. IF data is only selected while IF_Valid=1,
  // so undefined IF data during idle cycles cannot leak into ID.
  always_comb begin
    bus.ID_Valid       = id_valid;
    bus.ID_Instruction = '0;
    bus.ID_PCAdd4      = '0;
    bus.ID_PC          = '0;
    bus.ID_IsBDS       = 1'b0;
    if (!empty) begin
      bus.ID_Instruction = mem_instr[rd_ptr];
      bus.ID_PCAdd4      = mem_pcadd4[rd_ptr];
      bus.ID_PC          = mem_pc[rd_ptr];
      bus.ID_IsBDS       = mem_bds[rd_ptr];
    end
`ifdef IFQ_BYPASS_EN
    else if (bypass) begin
      bus.ID_Instruction = bus.IF_Instruction;
      bus.ID_PCAdd4      = bus.IF_PCAdd4;
      bus.ID_PC          = bus.IF_PCOut;
      bus.ID_IsBDS       = bus.IF_IsBDS;
    end
`endif
  end

  // Status outputs; IF_Ready depends on occupancy only, so a flush does not
  // change it until the following cycle.
  always_comb begin
    bus.IF_Ready = ~full;
    bus.Count    = count_q;
  end

endmodule

// File: tb/tb_ifid_fetch_queue.sv
// tb_ifid_fetch_queue
//   Drives a DEPTH=2 and a DEPTH=4 instance with identical stimulus. A queue-based
//   reference model per instance predicts every output. Directed scenarios cover
//   reset, fill/drain, wrap-around, flush, delay-slot tagging and the bypass
//   feature (selected by IFQ_BYPASS_EN); a randomized phase covers the rest.

module tb_ifid_fetch_queue;

  localparam int W = 32 + 32 + 32 + 1;  // {instr, pcadd4, pc, bds}
`ifdef IFQ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic in_reset;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog: the run must always end on its own.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- shared stimulus ----------------
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pcadd4;
  logic [31:0] in_pc;
  logic        in_bds;
  logic        in_flush;
  logic        in_stall;

  ifid_fetch_queue_if #(.DEPTH(2), .PC_W(32), .INSTR_W(32)) bus2 ();
  ifid_fetch_queue_if #(.DEPTH(4), .PC_W(32), .INSTR_W(32)) bus4 ();

  assign bus2.IF_Valid       = in_valid;
  assign bus2.IF_Instruction = in_instr;
  assign bus2.IF_PCAdd4      = in_pcadd4;
  assign bus2.IF_PCOut       = in_pc;
  assign bus2.IF_IsBDS       = in_bds;
  assign bus2.IF_Flush       = in_flush;
  assign bus2.ID_Stall       = in_stall;

  assign bus4.IF_Valid       = in_valid;
  assign bus4.IF_Instruction = in_instr;
  assign bus4.IF_PCAdd4      = in_pcadd4;
  assign bus4.IF_PCOut       = in_pc;
  assign bus4.IF_IsBDS       = in_bds;
  assign bus4.IF_Flush       = in_flush;
  assign bus4.ID_Stall       = in_stall;

  ifid_fetch_queue #(.DEPTH(2), .PC_W(32), .INSTR_W(32)) dut2 (
    .clock (clk),
    .reset (in_reset),
    .bus   (bus2)
  );

  ifid_fetch_queue #(.DEPTH(4), .PC_W(32), .INSTR_W(32)) dut4 (
    .clock (clk),
    .reset (in_reset),
    .bus   (bus4)
  );

  // Observed outputs, index 0 = DEPTH 2, index 1 = DEPTH 4.
  logic        obs_valid  [2];
  logic        obs_ready  [2];
  logic        obs_bds    [2];
  logic [31:0] obs_instr  [2];
  logic [31:0] obs_pcadd4 [2];
  logic [31:0] obs_pc     [2];
  logic [31:0] obs_count  [2];

  assign obs_valid[0]  = bus2.ID_Valid;
  assign obs_ready[0]  = bus2.IF_Ready;
  assign obs_bds[0]    = bus2.ID_IsBDS;
  assign obs_instr[0]  = bus2.ID_Instruction;
  assign obs_pcadd4[0] = bus2.ID_PCAdd4;
  assign obs_pc[0]     = bus2.ID_PC;
  assign obs_count[0]  = 32'(bus2.Count);

  assign obs_valid[1]  = bus4.ID_Valid;
  assign obs_ready[1]  = bus4.IF_Ready;
  assign obs_bds[1]    = bus4.ID_IsBDS;
  assign obs_instr[1]  = bus4.ID_Instruction;
  assign obs_pcadd4[1] = bus4.ID_PCAdd4;
  assign obs_pc[1]     = bus4.ID_PC;
  assign obs_count[1]  = 32'(bus4.Count);

  // ---------------- scoreboard / reference model ----------------
  logic [W-1:0] exp_q0[$];  // DEPTH 2 contents, head at index 0
  logic [W-1:0] exp_q1[$];  // DEPTH 4 contents
  int n_checks;
  int n_errors;

  function automatic int m_depth(int k);
    return (k == 0) ? 2 : 4;
  endfunction

  function automatic int m_size(int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [W-1:0] m_head(int k);
    if (k == 0) return exp_q0[0];
    return exp_q1[0];
  endfunction

  function automatic logic [W-1:0] in_entry();
    return {in_instr, in_pcadd4, in_pc, in_bds};
  endfunction

  function automatic bit m_ready(int k);
    return m_size(k) < m_depth(k);
  endfunction

  function automatic bit m_bypass(int k);
    return BYPASS && (m_size(k) == 0) && in_valid && !in_flush && !in_stall;
  endfunction

  function automatic bit m_id_valid(int k);
    return (m_size(k) > 0) || m_bypass(k);
  endfunction

  function automatic logic [W-1:0] m_entry(int k);
    if (m_size(k) > 0) return m_head(k);
    if (m_bypass(k)) return in_entry();
    return '0;
  endfunction

  // Advance the model by one clock using the inputs held this cycle.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit do_push;
      bit do_pop;
      bit byp;
      if (in_reset || in_flush) begin
        if (k == 0) exp_q0.delete(); else exp_q1.delete();
      end else begin
        byp     = m_bypass(k);
        do_push = in_valid && m_ready(k);
        do_pop  = m_id_valid(k) && !in_stall;
        if (!byp) begin
          if (do_pop) begin
            if (k == 0) exp_q0.delete(0); else exp_q1.delete(0);
          end
          if (do_push) begin
            if (k == 0) exp_q0.push_back(in_entry()); else exp_q1.push_back(in_entry());
          end
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; inputs stay stable until the next negedge.
  task automatic set_in(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic bds, input logic flush, input logic stall);
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc;
    in_pcadd4 = pc + 32'd4;
    in_bds    = bds;
    in_flush  = flush;
    in_stall  = stall;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drain();
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (m_size(0) == 0 && m_size(1) == 0) break;
      tick();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    in_reset = 1'b1;
    set_in(1'b1, 32'h1234_5678, 32'h40, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    in_reset = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (obs_count[k] !== 32'd0) begin n_errors++; $display("FAIL reset_count[%0d] got=%0d exp=0", k, obs_count[k]); end
      n_checks++; if (obs_valid[k] !== 1'b0) begin n_errors++; $display("FAIL reset_valid[%0d] got=%0b exp=0", k, obs_valid[k]); end
      n_checks++; if (obs_instr[k] !== 32'h0) begin n_errors++; $display("FAIL reset_instr[%0d] got=%08h exp=0", k, obs_instr[k]); end
      n_checks++; if (obs_ready[k] !== 1'b1) begin n_errors++; $display("FAIL reset_ready[%0d] got=%0b exp=1", k, obs_ready[k]); end
    end
  endtask

  task automatic test_fill_drain();
    set_in(1'b1, 32'h0000_0001, 32'h100, 1'b0, 1'b0, 1'b1);
    #1;
    n_checks++; if (obs_ready[0] !== 1'b1) begin n_errors++; $display("FAIL fill_ready0 got=%0b exp=1", obs_ready[0]); end
    tick();
    set_in(1'b1, 32'h0000_0002, 32'h104, 1'b0, 1'b0, 1'b1);
    tick();
    set_in(1'b1, 32'h0000_0003, 32'h108, 1'b0, 1'b0, 1'b1);
    #1;
    n_checks++; if (obs_count[0] !== 32'd2) begin n_errors++; $display("FAIL fill_count got=%0d exp=2", obs_count[0]); end
    n_checks++; if (obs_ready[0] !== 1'b0) begin n_errors++; $display("FAIL fill_ready_full got=%0b exp=0", obs_ready[0]); end
    tick();
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++; if (obs_count[0] !== 32'd2) begin n_errors++; $display("FAIL third_push_refused got=%0d exp=2", obs_count[0]); end
    n_checks++; if (obs_valid[0] !== 1'b1 || obs_pc[0] !== 32'h100) begin n_errors++; $display("FAIL drain_first got=%0b/%08h exp=1/00000100", obs_valid[0], obs_pc[0]); end
    tick();
    #1;
    n_checks++; if (obs_valid[0] !== 1'b1 || obs_pc[0] !== 32'h104) begin n_errors++; $display("FAIL drain_second got=%0b/%08h exp=1/00000104", obs_valid[0], obs_pc[0]); end
    tick();
    #1;
    n_checks++; if (obs_valid[0] !== 1'b0 || obs_pc[0] !== 32'h0) begin n_errors++; $display("FAIL drain_empty got=%0b/%08h exp=0/00000000", obs_valid[0], obs_pc[0]); end
    // The DEPTH 4 instance accepted the third push as well.
    n_checks++; if (obs_valid[1] !== 1'b1 || obs_pc[1] !== 32'h108) begin n_errors++; $display("FAIL d4_third_entry got=%0b/%08h exp=1/00000108", obs_valid[1], obs_pc[1]); end
    drain();
  endtask

  task automatic test_wrap();
    set_in(1'b1, 32'hA000_0000, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    for (int i = 1; i <= 10; i++) begin
      set_in(1'b1, 32'hA000_0000 + 32'(i), 32'(4 * i), 1'b0, 1'b0, 1'b0);
      #1;
      for (int k = 0; k < 2; k++) begin
        n_checks++; if (obs_pc[k] !== 32'(4 * (i - 1)) || obs_valid[k] !== 1'b1) begin n_errors++; $display("FAIL wrap_pc[%0d] step=%0d got=%0b/%08h exp=1/%08h", k, i, obs_valid[k], obs_pc[k], 4 * (i - 1)); end
        n_checks++; if (obs_count[k] !== 32'd1) begin n_errors++; $display("FAIL wrap_count[%0d] step=%0d got=%0d exp=1", k, i, obs_count[k]); end
      end
      tick();
    end
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++; if (obs_pc[1] !== 32'h28 || obs_instr[1] !== 32'hA000_000A) begin n_errors++; $display("FAIL wrap_last got=%08h/%08h exp=00000028/a000000a", obs_pc[1], obs_instr[1]); end
    tick();
    #1;
    n_checks++; if (obs_valid[1] !== 1'b0) begin n_errors++; $display("FAIL wrap_empty got=%0b exp=0", obs_valid[1]); end
  endtask

  task automatic test_flush();
    set_in(1'b1, 32'h0000_0011, 32'h300, 1'b0, 1'b0, 1'b1);
    tick();
    set_in(1'b1, 32'h0000_0012, 32'h304, 1'b0, 1'b0, 1'b1);
    tick();
    set_in(1'b1, 32'hDEAD_BEEF, 32'h308, 1'b0, 1'b1, 1'b0);
    #1;
    n_checks++; if (obs_count[0] !== 32'd2) begin n_errors++; $display("FAIL flush_setup_count got=%0d exp=2", obs_count[0]); end
    n_checks++; if (obs_ready[0] !== 1'b0) begin n_errors++; $display("FAIL flush_cycle_ready_full got=%0b exp=0", obs_ready[0]); end
    n_checks++; if (obs_ready[1] !== 1'b1) begin n_errors++; $display("FAIL flush_cycle_ready_d4 got=%0b exp=1", obs_ready[1]); end
    tick();
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        n_checks++; if (obs_count[k] !== 32'd0) begin n_errors++; $display("FAIL flush_count[%0d] cyc=%0d got=%0d exp=0", k, c, obs_count[k]); end
        n_checks++; if (obs_valid[k] !== 1'b0 || obs_instr[k] !== 32'h0) begin n_errors++; $display("FAIL flush_valid[%0d] cyc=%0d got=%0b/%08h exp=0/00000000", k, c, obs_valid[k], obs_instr[k]); end
      end
      tick();
    end
  endtask

  task automatic test_bds();
    set_in(1'b1, 32'h1000_0003, 32'h200, 1'b0, 1'b0, 1'b1);
    tick();
    set_in(1'b1, 32'h0000_0000, 32'h204, 1'b1, 1'b0, 1'b1);
    tick();
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++; if (obs_pc[0] !== 32'h200 || obs_bds[0] !== 1'b0) begin n_errors++; $display("FAIL bds_branch got=%08h/%0b exp=00000200/0", obs_pc[0], obs_bds[0]); end
    tick();
    #1;
    n_checks++; if (obs_pc[0] !== 32'h204 || obs_bds[0] !== 1'b1) begin n_errors++; $display("FAIL bds_slot got=%08h/%0b exp=00000204/1", obs_pc[0], obs_bds[0]); end
    n_checks++; if (obs_pcadd4[0] !== 32'h208) begin n_errors++; $display("FAIL bds_pcadd4 got=%08h exp=00000208", obs_pcadd4[0]); end
    tick();
    #1;
    n_checks++; if (obs_bds[0] !== 1'b0 || obs_valid[0] !== 1'b0) begin n_errors++; $display("FAIL bds_after got=%0b/%0b exp=0/0", obs_bds[0], obs_valid[0]); end
    drain();
  endtask

  task automatic test_bypass();
    set_in(1'b1, 32'h8C01_0004, 32'h400, 1'b0, 1'b0, 1'b0);
    #1;
`ifdef IFQ_BYPASS_EN
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (obs_valid[k] !== 1'b1 || obs_instr[k] !== 32'h8C01_0004) begin n_errors++; $display("FAIL bypass_same_cycle[%0d] got=%0b/%08h exp=1/8c010004", k, obs_valid[k], obs_instr[k]); end
      n_checks++; if (obs_count[k] !== 32'd0) begin n_errors++; $display("FAIL bypass_count[%0d] got=%0d exp=0", k, obs_count[k]); end
    end
    tick();
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++; if (obs_valid[0] !== 1'b0 || obs_count[0] !== 32'd0) begin n_errors++; $display("FAIL bypass_not_stored got=%0b/%0d exp=0/0", obs_valid[0], obs_count[0]); end
`else
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (obs_valid[k] !== 1'b0 || obs_instr[k] !== 32'h0) begin n_errors++; $display("FAIL nobypass_same_cycle[%0d] got=%0b/%08h exp=0/00000000", k, obs_valid[k], obs_instr[k]); end
    end
    tick();
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (obs_valid[k] !== 1'b1 || obs_instr[k] !== 32'h8C01_0004) begin n_errors++; $display("FAIL nobypass_next_cycle[%0d] got=%0b/%08h exp=1/8c010004", k, obs_valid[k], obs_instr[k]); end
      n_checks++; if (obs_count[k] !== 32'd1) begin n_errors++; $display("FAIL nobypass_count[%0d] got=%0d exp=1", k, obs_count[k]); end
    end
    tick();
`endif
    // Empty + push + stall: stored normally in both builds.
    set_in(1'b1, 32'h2402_0001, 32'h500, 1'b0, 1'b0, 1'b1);
    #1;
    n_checks++; if (obs_valid[0] !== 1'b0) begin n_errors++; $display("FAIL stall_push_same_cycle got=%0b exp=0", obs_valid[0]); end
    tick();
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++; if (obs_valid[0] !== 1'b1 || obs_instr[0] !== 32'h2402_0001 || obs_count[0] !== 32'd1) begin n_errors++; $display("FAIL stall_push_stored got=%0b/%08h/%0d exp=1/24020001/1", obs_valid[0], obs_instr[0], obs_count[0]); end
    tick();
    // Empty + push + flush: nothing reaches ID, nothing is stored.
    set_in(1'b1, 32'h2403_0002, 32'h600, 1'b0, 1'b1, 1'b0);
    #1;
    n_checks++; if (obs_valid[0] !== 1'b0 || obs_instr[0] !== 32'h0) begin n_errors++; $display("FAIL flush_push_same_cycle got=%0b/%08h exp=0/00000000", obs_valid[0], obs_instr[0]); end
    tick();
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++; if (obs_valid[0] !== 1'b0 || obs_count[0] !== 32'd0) begin n_errors++; $display("FAIL flush_push_dropped got=%0b/%0d exp=0/0", obs_valid[0], obs_count[0]); end
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    int stall_pct;
    for (int c = 0; c < 600; c++) begin
      stall_pct = ((c / 100) % 2 == 1) ? 70 : 20;
      in_reset  = ($urandom_range(0, 99) < 2);
      // Idle cycles carry junk data that must never reach ID.
      set_in(!in_reset && ($urandom_range(0, 99) < 65), $urandom, $urandom & 32'hFFFF_FFFC,
             1'($urandom_range(0, 1)), !in_reset && ($urandom_range(0, 99) < 5),
             $urandom_range(0, 99) < stall_pct);
      #1;
      for (int k = 0; k < 2; k++) begin
        e = m_entry(k);
        n_checks++; if (obs_valid[k] !== m_id_valid(k)) begin n_errors++; $display("FAIL rnd_valid[%0d] cyc=%0d got=%0b exp=%0b", k, c, obs_valid[k], m_id_valid(k)); end
        n_checks++; if (obs_ready[k] !== m_ready(k)) begin n_errors++; $display("FAIL rnd_ready[%0d] cyc=%0d got=%0b exp=%0b", k, c, obs_ready[k], m_ready(k)); end
        n_checks++; if (obs_count[k] !== 32'(m_size(k))) begin n_errors++; $display("FAIL rnd_count[%0d] cyc=%0d got=%0d exp=%0d", k, c, obs_count[k], m_size(k)); end
        n_checks++; if ({obs_instr[k], obs_pcadd4[k], obs_pc[k], obs_bds[k]} !== e) begin n_errors++; $display("FAIL rnd_data[%0d] cyc=%0d got=%08h/%08h/%08h/%0b exp=%08h/%08h/%08h/%0b", k, c, obs_instr[k], obs_pcadd4[k], obs_pc[k], obs_bds[k], e[96:65], e[64:33], e[32:1], e[0]); end
      end
      tick();
    end
    in_reset = 1'b0;
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    in_reset = 1'b1;
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_wrap();
    test_flush();
    test_bds();
    test_bypass();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
